// File: rtl/defines_pkg.sv
// -----------------------------------------------------------------------------
// defines_pkg
//   Shared constants and types for the fetch stage.
//   NOP_INST   : instruction word injected into ID as a pipeline bubble.
//   PC_INC     : byte stride between sequential instructions.
//   fetch_state_t : fetch FSM states (RUN, HALTED).
//   ifid_op_t  : what the IF/ID register does this cycle (hold, bubble, load).
// -----------------------------------------------------------------------------
package defines_pkg;

  localparam logic [15:0] NOP_INST = 16'h0800;
  localparam logic [15:0] PC_INC   = 16'd2;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// -----------------------------------------------------------------------------
// fetch_pc_sel
//   Combinational priority mux for the fetch stage. Given the current PC, EPC,
//   FSM state and the redirect/stall events, it produces the next PC, next EPC,
//   next FSM state and the action for the IF/ID register.
// Ports:
//   state_i, pc_i, epc_i, nxt_pc_p1_i : current architectural state
//   stall_i, halt_i, illegal_i, rti_i, jmp_i, jmp_disp_i : decode events
//   redirect_i, redirect_pc_i        : execute redirect
//   pc_d_o, epc_d_o, state_d_o       : next-state values
//   ifid_op_o                         : IF/ID register action
// -----------------------------------------------------------------------------
module fetch_pc_sel
  import defines_pkg::*;
#(
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  fetch_state_t state_i,
  input  logic [15:0]  pc_i,
  input  logic [15:0]  epc_i,
  input  logic [15:0]  nxt_pc_p1_i,
  input  logic         stall_i,
  input  logic         halt_i,
  input  logic         illegal_i,
  input  logic         rti_i,
  input  logic         jmp_i,
  input  logic [15:0]  jmp_disp_i,
  input  logic         redirect_i,
  input  logic [15:0]  redirect_pc_i,
  output logic [15:0]  pc_d_o,
  output logic [15:0]  epc_d_o,
  output fetch_state_t state_d_o,
  output ifid_op_t     ifid_op_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // priority chain can leave one unassigned and infer a latch.
    pc_d_o    = pc_i;
    epc_d_o   = epc_i;
    state_d_o = state_i;
    ifid_op_o = IFID_HOLD;

    if (state_i == HALTED) begin
      // Frozen until reset; ID keeps seeing NOPs.
      ifid_op_o = IFID_BUBBLE;
    end else if (redirect_i) begin
      // Execute redirect overrides a stall: the stalled ID instruction is on
      // the wrong path anyway, so it is flushed.
      pc_d_o    = redirect_pc_i;
      ifid_op_o = IFID_BUBBLE;
    end else if (stall_i) begin
      // Same instruction is re-presented to decode, so its events are ignored.
      ifid_op_o = IFID_HOLD;
    end else if (halt_i) begin
      state_d_o = HALTED;
      ifid_op_o = IFID_BUBBLE;
    end else if (illegal_i) begin
      epc_d_o   = nxt_pc_p1_i;
      pc_d_o    = EXC_VECTOR;
      ifid_op_o = IFID_BUBBLE;
    end else if (rti_i) begin
      pc_d_o    = epc_i;
      ifid_op_o = IFID_BUBBLE;
    end else if (jmp_i) begin
      pc_d_o    = nxt_pc_p1_i + jmp_disp_i;
      ifid_op_o = IFID_BUBBLE;
    end else begin
      pc_d_o    = pc_i + PC_INC;
      ifid_op_o = IFID_LOAD;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage plus the IF/ID pipeline register. Owns the PC, the
//   EPC and the RUN/HALTED state; next-state selection lives in fetch_pc_sel.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   imem_addr / imem_rdata          : instruction memory (same-cycle read)
//   stall_idif_p1                   : hold PC and IF/ID
//   halt/illegal_op/return_execution/jmp_displacement_idif_p1 : decode events
//   jmp_displacement_value_idif_p1  : sign-extended jump displacement
//   redirect_ixif_p1, redirect_pc_ixif_p1 : execute redirect and target
//   inst_ifid_p1, pc_p1, nxt_pc_p1  : IF/ID register contents
//   epc_p1                          : exception return PC
//   halted_p1                       : high while HALTED
// -----------------------------------------------------------------------------
module inst_fetch
  import defines_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        stall_idif_p1,
  input  logic        halt_idif_p1,
  input  logic        illegal_op_idif_p1,
  input  logic        return_execution_idif_p1,
  input  logic        jmp_displacement_idif_p1,
  input  logic [15:0] jmp_displacement_value_idif_p1,
  input  logic        redirect_ixif_p1,
  input  logic [15:0] redirect_pc_ixif_p1,
  output logic [15:0] inst_ifid_p1,
  output logic [15:0] pc_p1,
  output logic [15:0] nxt_pc_p1,
  output logic [15:0] epc_p1,
  output logic        halted_p1
);

  logic [15:0]  pc_q, pc_d;
  logic [15:0]  epc_q, epc_d;
  fetch_state_t state_q, state_d;
  ifid_op_t     ifid_op;
  logic [15:0]  inst_q;
  logic [15:0]  pc_p1_q;
  logic [15:0]  nxt_pc_p1_q;

  fetch_pc_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_pc_sel (
    .state_i       (state_q),
    .pc_i          (pc_q),
    .epc_i         (epc_q),
    .nxt_pc_p1_i   (nxt_pc_p1_q),
    .stall_i       (stall_idif_p1),
    .halt_i        (halt_idif_p1),
    .illegal_i     (illegal_op_idif_p1),
    .rti_i         (return_execution_idif_p1),
    .jmp_i         (jmp_displacement_idif_p1),
    .jmp_disp_i    (jmp_displacement_value_idif_p1),
    .redirect_i    (redirect_ixif_p1),
    .redirect_pc_i (redirect_pc_ixif_p1),
    .pc_d_o        (pc_d),
    .epc_d_o       (epc_d),
    .state_d_o     (state_d),
    .ifid_op_o     (ifid_op)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      state_q     <= RUN;
      inst_q      <= NOP_INST;
      pc_p1_q     <= '0;
      nxt_pc_p1_q <= '0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      state_q <= state_d;
      case (ifid_op)
        IFID_LOAD: begin
          inst_q      <= imem_rdata;
          pc_p1_q     <= pc_q;
          nxt_pc_p1_q <= pc_q + PC_INC;
        end
        // A bubble replaces only the instruction; pc_p1/nxt_pc_p1 keep their
        // values so a later exception still sees a sensible return address.
        IFID_BUBBLE: inst_q <= NOP_INST;
        default: ;
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign inst_ifid_p1 = inst_q;
  assign pc_p1        = pc_p1_q;
  assign nxt_pc_p1    = nxt_pc_p1_q;
  assign epc_p1       = epc_q;
  assign halted_p1    = (state_q == HALTED);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall_idif_p1;
  logic        halt_idif_p1;
  logic        illegal_op_idif_p1;
  logic        return_execution_idif_p1;
  logic        jmp_displacement_idif_p1;
  logic [15:0] jmp_displacement_value_idif_p1;
  logic        redirect_ixif_p1;
  logic [15:0] redirect_pc_ixif_p1;
  logic [15:0] inst_ifid_p1;
  logic [15:0] pc_p1;
  logic [15:0] nxt_pc_p1;
  logic [15:0] epc_p1;
  logic        halted_p1;

  int errors = 0;
  int checks = 0;

  inst_fetch #(
    .RESET_PC  (16'h0000),
    .EXC_VECTOR(16'h0002)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .imem_addr                     (imem_addr),
    .imem_rdata                    (imem_rdata),
    .stall_idif_p1                 (stall_idif_p1),
    .halt_idif_p1                  (halt_idif_p1),
    .illegal_op_idif_p1            (illegal_op_idif_p1),
    .return_execution_idif_p1      (return_execution_idif_p1),
    .jmp_displacement_idif_p1      (jmp_displacement_idif_p1),
    .jmp_displacement_value_idif_p1(jmp_displacement_value_idif_p1),
    .redirect_ixif_p1              (redirect_ixif_p1),
    .redirect_pc_ixif_p1           (redirect_pc_ixif_p1),
    .inst_ifid_p1                  (inst_ifid_p1),
    .pc_p1                         (pc_p1),
    .nxt_pc_p1                     (nxt_pc_p1),
    .epc_p1                        (epc_p1),
    .halted_p1                     (halted_p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_idif_p1                  = 1'b0;
    halt_idif_p1                   = 1'b0;
    illegal_op_idif_p1             = 1'b0;
    return_execution_idif_p1       = 1'b0;
    jmp_displacement_idif_p1       = 1'b0;
    jmp_displacement_value_idif_p1 = 16'h0000;
    redirect_ixif_p1               = 1'b0;
    redirect_pc_ixif_p1            = 16'h0000;
  endtask

  // Execute redirect to 'target', then one sequential fetch: leaves
  // pc_p1 = target, nxt_pc_p1 = target+2, imem_addr = target+2.
  task automatic goto_pc(input logic [15:0] target);
    redirect_ixif_p1    = 1'b1;
    redirect_pc_ixif_p1 = target;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    imem_rdata = 16'h4123;
    rst = 1'b1;
    #12;
    checks++;
    if (imem_addr !== 16'h0000 || inst_ifid_p1 !== 16'h0800 || pc_p1 !== 16'h0000 ||
        nxt_pc_p1 !== 16'h0000 || epc_p1 !== 16'h0000 || halted_p1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: addr=%h inst=%h pc_p1=%h nxt=%h epc=%h halted=%b expected 0000 0800 0000 0000 0000 0",
               imem_addr, inst_ifid_p1, pc_p1, nxt_pc_p1, epc_p1, halted_p1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    imem_rdata = 16'h4123;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = 16'(2 * i);
      checks++;
      if (pc_p1 !== exp_pc || nxt_pc_p1 !== exp_pc + 16'd2 || inst_ifid_p1 !== 16'h4123) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: pc_p1=%h nxt=%h inst=%h expected %h %h 4123",
                 i, pc_p1, nxt_pc_p1, inst_ifid_p1, exp_pc, exp_pc + 16'd2);
      end
    end
    checks++;
    if (imem_addr !== 16'h0006) begin
      errors++;
      $display("FAIL seq_addr: imem_addr=%h expected 0006", imem_addr);
    end
  endtask

  task automatic test_jump();
    imem_rdata = 16'h4123;
    goto_pc(16'h000E);
    checks++;
    if (nxt_pc_p1 !== 16'h0010) begin
      errors++;
      $display("FAIL jmp_setup: nxt_pc_p1=%h expected 0010", nxt_pc_p1);
    end
    jmp_displacement_idif_p1       = 1'b1;
    jmp_displacement_value_idif_p1 = 16'hFFF8;
    step();
    clear_inputs();
    checks++;
    if (imem_addr !== 16'h0008 || inst_ifid_p1 !== 16'h0800 || pc_p1 !== 16'h000E) begin
      errors++;
      $display("FAIL jmp_target: addr=%h inst=%h pc_p1=%h expected 0008 0800 000e",
               imem_addr, inst_ifid_p1, pc_p1);
    end
    imem_rdata = 16'h5A5A;
    step();
    checks++;
    if (inst_ifid_p1 !== 16'h5A5A || pc_p1 !== 16'h0008 || imem_addr !== 16'h000A) begin
      errors++;
      $display("FAIL jmp_one_bubble: inst=%h pc_p1=%h addr=%h expected 5a5a 0008 000a",
               inst_ifid_p1, pc_p1, imem_addr);
    end
  endtask

  task automatic test_illegal_rti();
    goto_pc(16'h0020);
    // Illegal op together with a jump: illegal has priority.
    illegal_op_idif_p1             = 1'b1;
    jmp_displacement_idif_p1       = 1'b1;
    jmp_displacement_value_idif_p1 = 16'h0100;
    step();
    clear_inputs();
    checks++;
    if (epc_p1 !== 16'h0022 || imem_addr !== 16'h0002 || inst_ifid_p1 !== 16'h0800) begin
      errors++;
      $display("FAIL illegal_op: epc=%h addr=%h inst=%h expected 0022 0002 0800",
               epc_p1, imem_addr, inst_ifid_p1);
    end
    step();
    checks++;
    if (pc_p1 !== 16'h0002 || imem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL exc_vector_fetch: pc_p1=%h addr=%h expected 0002 0004", pc_p1, imem_addr);
    end
    return_execution_idif_p1 = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (imem_addr !== 16'h0022 || inst_ifid_p1 !== 16'h0800 || epc_p1 !== 16'h0022) begin
      errors++;
      $display("FAIL rti: addr=%h inst=%h epc=%h expected 0022 0800 0022",
               imem_addr, inst_ifid_p1, epc_p1);
    end
  endtask

  task automatic test_stall_redirect();
    imem_rdata = 16'h1111;
    goto_pc(16'h0030);
    stall_idif_p1 = 1'b1;
    halt_idif_p1  = 1'b1;
    imem_rdata    = 16'h2222;
    step();
    checks++;
    if (imem_addr !== 16'h0032 || inst_ifid_p1 !== 16'h1111 || pc_p1 !== 16'h0030 || halted_p1 !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: addr=%h inst=%h pc_p1=%h halted=%b expected 0032 1111 0030 0",
               imem_addr, inst_ifid_p1, pc_p1, halted_p1);
    end
    redirect_ixif_p1    = 1'b1;
    redirect_pc_ixif_p1 = 16'h0100;
    step();
    clear_inputs();
    checks++;
    if (imem_addr !== 16'h0100 || inst_ifid_p1 !== 16'h0800 || halted_p1 !== 1'b0 || pc_p1 !== 16'h0030) begin
      errors++;
      $display("FAIL stall_redirect: addr=%h inst=%h halted=%b pc_p1=%h expected 0100 0800 0 0030",
               imem_addr, inst_ifid_p1, halted_p1, pc_p1);
    end
  endtask

  task automatic test_halt();
    int bad;
    imem_rdata = 16'h3333;
    goto_pc(16'h0040);
    halt_idif_p1 = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (halted_p1 !== 1'b1 || imem_addr !== 16'h0042 || inst_ifid_p1 !== 16'h0800) begin
      errors++;
      $display("FAIL halt_enter: halted=%b addr=%h inst=%h expected 1 0042 0800",
               halted_p1, imem_addr, inst_ifid_p1);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      redirect_ixif_p1    = (i == 3);
      redirect_pc_ixif_p1 = 16'h0200;
      illegal_op_idif_p1  = (i == 5);
      step();
      if (halted_p1 !== 1'b1 || imem_addr !== 16'h0042 || pc_p1 !== 16'h0040 ||
          inst_ifid_p1 !== 16'h0800 || epc_p1 !== 16'h0022)
        bad++;
    end
    clear_inputs();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_frozen: %0d of 10 cycles moved (last addr=%h halted=%b) expected addr 0042 halted 1",
               bad, imem_addr, halted_p1);
    end
    // Mid-cycle reset: must take effect without any clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (halted_p1 !== 1'b0 || imem_addr !== 16'h0000 || pc_p1 !== 16'h0000 || epc_p1 !== 16'h0000 ||
        inst_ifid_p1 !== 16'h0800) begin
      errors++;
      $display("FAIL async_reset: halted=%b addr=%h pc_p1=%h epc=%h inst=%h expected 0 0000 0000 0000 0800",
               halted_p1, imem_addr, pc_p1, epc_p1, inst_ifid_p1);
    end
    #1 rst = 1'b0;
    imem_rdata = 16'h7777;
    step();
    checks++;
    if (pc_p1 !== 16'h0000 || inst_ifid_p1 !== 16'h7777 || imem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL post_reset_fetch: pc_p1=%h inst=%h addr=%h expected 0000 7777 0002",
               pc_p1, inst_ifid_p1, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_ixif_p1    = 1'b1;
    redirect_pc_ixif_p1 = 16'hFFFE;
    step();
    clear_inputs();
    checks++;
    if (imem_addr !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_setup: addr=%h expected fffe", imem_addr);
    end
    imem_rdata = 16'h9ABC;
    step();
    checks++;
    if (imem_addr !== 16'h0000 || pc_p1 !== 16'hFFFE || nxt_pc_p1 !== 16'h0000 || inst_ifid_p1 !== 16'h9ABC) begin
      errors++;
      $display("FAIL wrap: addr=%h pc_p1=%h nxt=%h inst=%h expected 0000 fffe 0000 9abc",
               imem_addr, pc_p1, nxt_pc_p1, inst_ifid_p1);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_illegal_rti();
    test_stall_redirect();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
